// File: rtl/prod_bcd_pkg.sv
// Shared types and constants for the product-to-BCD converter.
package prod_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_ADD    = 3;

  // Shift counter width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adj
  import prod_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIGIT_W'(ADJ_THRESH)) begin
      digit_o = digit_i + DIGIT_W'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/prod_bcd_conv.sv
// Iterative binary-to-packed-BCD converter, one bit per clock, valid/ready on both sides.
module prod_bcd_conv
  import prod_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      busy
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]       adj_c;
  logic [BCD_W+WIDTH-1:0] shifted_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The top adjusted bit falls off here; with DIGITS at its bound it is always zero.
  assign shifted_c = {adj_c, bin_q} << 1;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_out_d   = bcd_out_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = shifted_c[BCD_W+WIDTH-1:WIDTH];
        bin_d = shifted_c[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_out_d = shifted_c[BCD_W+WIDTH-1:WIDTH];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the upcoming state.
    unique case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      SHIFT:   busy_d      = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: in_ready_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_out_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_out_q   <= bcd_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Randomized and directed bench for prod_bcd_conv against a decimal-arithmetic reference.
module tb_prod_bcd_conv;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned LAT_MAX = 40;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bin_in;
  logic             out_valid;
  logic             out_ready;
  logic [BCD_W-1:0] bcd_out;
  logic             busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  prod_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Decimal digits by repeated division.
  function automatic logic [BCD_W-1:0] ref_bcd(input int unsigned v);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; noise keeps in_valid high with another value while busy.
  task automatic convert(input logic [WIDTH-1:0] v, input int unsigned hold, input bit noise);
    logic [BCD_W-1:0] prev, held;
    int unsigned lat;
    bit rdy_seen, busy_lost, glitch, unstable;
    prev      = bcd_out;
    in_valid  = 1'b1;
    bin_in    = v;
    out_ready = 1'b0;
    tick();
    if (noise) bin_in = WIDTH'(42);
    else in_valid = 1'b0;
    lat = 0; rdy_seen = 0; busy_lost = 0; glitch = 0;
    while (!out_valid && lat < LAT_MAX) begin
      if (in_ready) rdy_seen = 1;
      if (!busy) busy_lost = 1;
      if (bcd_out !== prev) glitch = 1;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check($sformatf("latency_%0d", v), lat, WIDTH);
    check($sformatf("in_ready_low_%0d", v), 32'(rdy_seen), 0);
    check($sformatf("busy_high_%0d", v), 32'(busy_lost), 0);
    check($sformatf("no_glitch_%0d", v), 32'(glitch), 0);
    check($sformatf("bcd_%0d", v), 32'(bcd_out), 32'(ref_bcd(32'(v))));
    held = bcd_out;
    unstable = 0;
    for (int i = 0; i < int'(hold); i++) begin
      tick();
      if (!out_valid || in_ready || bcd_out !== held) unstable = 1;
    end
    if (hold > 0) check($sformatf("backpressure_%0d", v), 32'(unstable), 0);
    check($sformatf("in_ready_pre_hs_%0d", v), 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("idle_in_ready_%0d", v), 32'(in_ready), 1);
    check($sformatf("idle_out_valid_%0d", v), 32'(out_valid), 0);
    check($sformatf("idle_hold_bcd_%0d", v), 32'(bcd_out), 32'(held));
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int unsigned t, cyc, n_pulse;
    int unsigned pulse_cyc[2];
    logic [BCD_W-1:0] pulse_bcd[2];

    rst_n = 1'b0; in_valid = 1'b0; bin_in = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_bcd", 32'(bcd_out), 0);

    convert(16'd0, 0, 0);
    convert(16'd65535, 0, 0);
    convert(16'd1234, 5, 0);
    convert(16'd10, 0, 1);
    convert(16'd9999, 2, 0);

    for (int k = 0; k < 20; k++) begin
      v = WIDTH'($urandom);
      convert(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Handshake and new input in the same DONE cycle: only the handshake completes.
    in_valid = 1'b1; bin_in = 16'd77;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < LAT_MAX) begin tick(); t++; end
    in_valid = 1'b1; bin_in = 16'd88; out_ready = 1'b1;
    tick();
    check("simul_hs_idle", 32'(in_ready), 1);
    check("simul_hs_not_busy", 32'(busy), 0);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("simul_accept_next", 32'(busy), 1);
    t = 0;
    while (!out_valid && t < LAT_MAX) begin tick(); t++; end
    check("simul_bcd", 32'(bcd_out), 32'(ref_bcd(88)));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset partway through a conversion.
    in_valid = 1'b1; bin_in = 16'd65535;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_bcd", 32'(bcd_out), 0);
    t = 0;
    while (t < 20) begin
      if (out_valid) break;
      tick(); t++;
    end
    check("midrst_no_stale", 32'(out_valid), 0);
    convert(16'd500, 0, 0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1; in_valid = 1'b1; bin_in = 16'd7;
    tick();
    bin_in = 16'd300;
    cyc = 0; n_pulse = 0;
    while (n_pulse < 2 && cyc < 3 * LAT_MAX) begin
      if (out_valid) begin
        pulse_cyc[n_pulse] = cyc;
        pulse_bcd[n_pulse] = bcd_out;
        n_pulse++;
      end
      tick(); cyc++;
    end
    in_valid = 1'b0;
    check("b2b_pulses", n_pulse, 2);
    if (n_pulse == 2) begin
      check("b2b_first", 32'(pulse_bcd[0]), 32'(ref_bcd(7)));
      check("b2b_second", 32'(pulse_bcd[1]), 32'(ref_bcd(300)));
      check("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], WIDTH + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
